// File: rtl/cmv_capture_pkg.sv
// Shared types and constants for the CMV sensor capture packer.
//   state_e       : packer FSM states
//   HEADER_MAGIC  : upper half of the optional frame header word
//   pack_fits()   : elaboration-time check of pixel width / pixels-per-word
package cmv_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LINE  = 2'd1,
    ST_GAP   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam logic [15:0] HEADER_MAGIC = 16'hA5C3;

  // True when the pixel width is legal and a full word of pixels fits in 32 bits.
  function automatic bit pack_fits(input int unsigned pix_w, input int unsigned pix_per_word);
    return (pix_w >= 1) && (pix_w <= 16) && (pix_per_word >= 1) &&
           (pix_w * pix_per_word <= 32);
  endfunction

endpackage

// File: rtl/cmv_capture_packer_if.sv
// Downstream FIFO / USB handshake bundle of the capture packer.
//   fifo_wr_en : one-cycle write strobe          (master -> slave)
//   fifo_din   : packed 32-bit word              (master -> slave)
//   fifo_full  : FIFO cannot accept a write      (slave -> master)
//   fifo_bt    : block-transfer acknowledge      (slave -> master)
interface cmv_capture_packer_if;

  logic        fifo_wr_en;
  logic [31:0] fifo_din;
  logic        fifo_full;
  logic        fifo_bt;

  modport master (output fifo_wr_en, output fifo_din, input fifo_full, input fifo_bt);
  modport slave  (input fifo_wr_en, input fifo_din, output fifo_full, output fifo_bt);

endinterface

// File: rtl/cmv_sync_edge.sv
// Brings the asynchronous sensor pixel bus into the clk domain and flags the
// rising edge of the sensor pixel clock.
//   clk, reset_n             : system clock, synchronous active-low reset
//   cmv_clk_out              : sensor pixel clock, treated as data
//   cmv_lval, cmv_dval, cmv_d: sensor line-valid, data-valid, pixel
//   tick_c                   : one-cycle pulse on a sensor clock rising edge
//   lval, dval, d            : synchronised sensor signals, valid with tick_c
module cmv_sync_edge #(
  parameter int unsigned PIX_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmv_clk_out,
  input  logic             cmv_lval,
  input  logic             cmv_dval,
  input  logic [PIX_W-1:0] cmv_d,
  output logic             tick_c,
  output logic             lval,
  output logic             dval,
  output logic [PIX_W-1:0] d
);

  logic             clk_m;
  logic             clk_s;
  logic             clk_q;
  logic             lval_m;
  logic             dval_m;
  logic [PIX_W-1:0] d_m;

  // Two-flop synchronisers; data is stable around the sensor clock rising edge,
  // so per-bit synchronisation of the bus is coherent when tick_c fires.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_m  <= 1'b0;
      clk_s  <= 1'b0;
      clk_q  <= 1'b0;
      lval_m <= 1'b0;
      lval   <= 1'b0;
      dval_m <= 1'b0;
      dval   <= 1'b0;
      d_m    <= '0;
      d      <= '0;
    end else begin
      clk_m  <= cmv_clk_out;
      clk_s  <= clk_m;
      clk_q  <= clk_s;
      lval_m <= cmv_lval;
      lval   <= lval_m;
      dval_m <= cmv_dval;
      dval   <= dval_m;
      d_m    <= cmv_d;
      d      <= d_m;
    end
  end

  assign tick_c = clk_s & ~clk_q;

endmodule

// File: rtl/cmv_capture_packer.sv
// Packs CMV sensor pixels into 32-bit FIFO words, one line never sharing a word
// with the next, and tracks line / frame boundaries for USB readout.
//   clk, reset_n          : system clock, synchronous active-low reset
//   cmv_clk_out, cmv_lval,
//   cmv_dval, cmv_d       : asynchronous sensor pixel bus
//   capture_en            : level-sensitive capture enable
//   fifo (master)         : fifo_wr_en / fifo_din out, fifo_full / fifo_bt in
//   usb_ready             : frame complete, cleared by fifo_bt
//   frame_count           : completed frames (wraps)
//   line_count            : lines in the current frame
//   overflow              : sticky, a write was dropped on fifo_full
// Build option: define CMV_CAPTURE_HEADER_EN to precede each frame with a
// {16'hA5C3, frame_count} header word.
module cmv_capture_packer
  import cmv_capture_pkg::*;
#(
  parameter int unsigned PIX_W        = 10,
  parameter int unsigned PIX_PER_WORD = 3,
  parameter int unsigned FRAME_GAP    = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmv_clk_out,
  input  logic                 cmv_lval,
  input  logic                 cmv_dval,
  input  logic [PIX_W-1:0]     cmv_d,
  input  logic                 capture_en,
  cmv_capture_packer_if.master fifo,
  output logic                 usb_ready,
  output logic [15:0]          frame_count,
  output logic [15:0]          line_count,
  output logic                 overflow
);

  localparam int unsigned K_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  if (!pack_fits(PIX_W, PIX_PER_WORD)) begin : g_bad_pack
    $error("cmv_capture_packer: PIX_W*PIX_PER_WORD must fit in 32 bits, PIX_W in 1..16");
  end
  if ((FRAME_GAP < 2) || (FRAME_GAP > 65535)) begin : g_bad_gap
    $error("cmv_capture_packer: FRAME_GAP must be in 2..65535");
  end

  logic             tick;
  logic             lval;
  logic             dval;
  logic [PIX_W-1:0] pix;

  cmv_sync_edge #(.PIX_W(PIX_W)) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmv_clk_out(cmv_clk_out),
    .cmv_lval   (cmv_lval),
    .cmv_dval   (cmv_dval),
    .cmv_d      (cmv_d),
    .tick_c     (tick),
    .lval       (lval),
    .dval       (dval),
    .d          (pix)
  );

  state_e         state, state_nxt;
  logic [K_W-1:0] k, k_nxt;
  logic [31:0]    pack, pack_nxt;
  logic [15:0]    gap_cnt, gap_nxt;
  logic [15:0]    line_nxt, frame_nxt;
  logic           usb_nxt, ovf_nxt;
  logic           word_pend, pend_nxt;
  logic           wr_q, wr_nxt;
  logic [31:0]    din_q, din_nxt;
  logic           cap_en_q;

  logic           wr_req;
  logic           capture;
  logic           full_slot;
  logic [31:0]    packed_word;
  logic [16:0]    gap_inc;

  // Next-state, packing and write arbitration; only one write source per cycle.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    pack_nxt  = pack;
    gap_nxt   = gap_cnt;
    line_nxt  = line_count;
    frame_nxt = frame_count;
    usb_nxt   = fifo.fifo_bt ? 1'b0 : usb_ready;
    pend_nxt  = word_pend;
    wr_req    = 1'b0;
    din_nxt   = din_q;
    gap_inc   = {1'b0, gap_cnt} + 17'd1;

    packed_word = pack;
    for (int s = 0; s < int'(PIX_PER_WORD); s++) begin
      if (k == K_W'(s)) packed_word[s*PIX_W +: PIX_W] = pix;
    end

    capture   = tick & lval & dval &
                ((state == ST_LINE) |
                 (capture_en & ((state == ST_IDLE) | (state == ST_GAP))));
    full_slot = (k == K_W'(PIX_PER_WORD - 1));

    if (capture) begin
      if (full_slot) begin
        wr_req   = 1'b1;
        din_nxt  = packed_word;
        pack_nxt = '0;
        k_nxt    = '0;
      end else begin
        pack_nxt = packed_word;
        k_nxt    = k + K_W'(1);
      end
    end

    case (state)
      ST_IDLE: begin
        if (capture) begin
          state_nxt = ST_LINE;
`ifdef CMV_CAPTURE_HEADER_EN
          // Header takes this write slot; a word completed by the same pixel
          // is held and written in the following (tick-free) cycle.
          if (full_slot) begin
            pend_nxt = 1'b1;
            pack_nxt = packed_word;
          end
          wr_req  = 1'b1;
          din_nxt = {HEADER_MAGIC, frame_count};
`endif
        end
      end
      ST_LINE: begin
        if (word_pend) begin
          wr_req   = 1'b1;
          din_nxt  = pack;
          pack_nxt = '0;
          pend_nxt = 1'b0;
        end
        if (tick & ~lval) begin
          line_nxt = line_count + 16'd1;
          if (k != '0) state_nxt = ST_FLUSH;
          else         state_nxt = capture_en ? ST_GAP : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        wr_req    = 1'b1;
        din_nxt   = pack;
        pack_nxt  = '0;
        k_nxt     = '0;
        state_nxt = capture_en ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (tick) begin
          if (capture) begin
            gap_nxt   = '0;
            state_nxt = ST_LINE;
          end else if (~lval & ~dval) begin
            if (gap_inc == 17'(FRAME_GAP)) begin
              gap_nxt   = '0;
              usb_nxt   = 1'b1;
              frame_nxt = frame_count + 16'd1;
              line_nxt  = '0;
              state_nxt = ST_IDLE;
            end else begin
              gap_nxt = gap_inc[15:0];
            end
          end else begin
            gap_nxt = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    wr_nxt  = wr_req & ~fifo.fifo_full;
    ovf_nxt = ((capture_en & ~cap_en_q) ? 1'b0 : overflow) | (wr_req & fifo.fifo_full);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      k           <= '0;
      pack        <= '0;
      gap_cnt     <= '0;
      line_count  <= '0;
      frame_count <= '0;
      usb_ready   <= 1'b0;
      overflow    <= 1'b0;
      word_pend   <= 1'b0;
      wr_q        <= 1'b0;
      din_q       <= '0;
      cap_en_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      k           <= k_nxt;
      pack        <= pack_nxt;
      gap_cnt     <= gap_nxt;
      line_count  <= line_nxt;
      frame_count <= frame_nxt;
      usb_ready   <= usb_nxt;
      overflow    <= ovf_nxt;
      word_pend   <= pend_nxt;
      wr_q        <= wr_nxt;
      din_q       <= din_nxt;
      cap_en_q    <= capture_en;
    end
  end

  assign fifo.fifo_wr_en = wr_q;
  assign fifo.fifo_din   = din_q;

endmodule

// File: tb/tb_cmv_capture_packer.sv
// Randomised self-checking bench for cmv_capture_packer. A reference model
// builds the expected FIFO word stream per line from plain arithmetic; a
// monitor compares every write against it.
module tb_cmv_capture_packer;
  import cmv_capture_pkg::*;

  localparam int unsigned PIX_W = 10;
  localparam int unsigned PPW   = 3;
  localparam int unsigned GAP   = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cmv_clk_out;
  logic             cmv_lval;
  logic             cmv_dval;
  logic [PIX_W-1:0] cmv_d;
  logic             capture_en;
  logic             usb_ready;
  logic [15:0]      frame_count;
  logic [15:0]      line_count;
  logic             overflow;

  cmv_capture_packer_if fifo_bus ();

  cmv_capture_packer #(.PIX_W(PIX_W), .PIX_PER_WORD(PPW), .FRAME_GAP(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmv_clk_out(cmv_clk_out),
    .cmv_lval   (cmv_lval),
    .cmv_dval   (cmv_dval),
    .cmv_d      (cmv_d),
    .capture_en (capture_en),
    .fifo       (fifo_bus),
    .usb_ready  (usb_ready),
    .frame_count(frame_count),
    .line_count (line_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          exp_lines  = 0;
  int          exp_frames = 0;
  bit          exp_ovf    = 1'b0;
  bit          model_idle = 1'b1;
  logic        prev_wr    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every FIFO write must be the next word the model predicts.
  always @(negedge clk) begin
    if (fifo_bus.fifo_wr_en) begin
      check_eq("strobe_single_cycle", 32'(prev_wr), 32'd0);
      if (exp_q.size() == 0)
        check_eq("wr_unexpected", 32'(fifo_bus.fifo_wr_en), 32'd0);
      else
        check_eq("fifo_din", fifo_bus.fifo_din, exp_q.pop_front());
    end
    prev_wr = fifo_bus.fifo_wr_en;
  end

  task automatic settle();
    repeat (6) @(negedge clk);
  endtask

  task automatic sensor_tick(input logic lv, input logic dv, input logic [PIX_W-1:0] px);
    @(negedge clk);
    cmv_lval = lv; cmv_dval = dv; cmv_d = px; cmv_clk_out = 1'b0;
    repeat (2) @(negedge clk);
    cmv_clk_out = 1'b1;
    repeat (2) @(negedge clk);
    cmv_clk_out = 1'b0;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) sensor_tick(1'b0, 1'b0, '0);
  endtask

  task automatic set_en(input logic v);
    if (v && !capture_en) exp_ovf = 1'b0;
    @(negedge clk);
    capture_en = v;
    repeat (2) @(negedge clk);
  endtask

  // One sensor line of n pixels. fifo_full is held high over pixel ticks
  // ff_from..ff_to (index n = the line-end tick); capture_en drops before
  // pixel dis_at (-1 = never).
  task automatic send_line(input int n, input int ff_from, input int ff_to,
                           input bit rnd, input int dis_at);
    int px[$];
    bit cap;
    px.delete();
    for (int i = 0; i < n; i++)
      px.push_back(rnd ? int'($urandom_range(0, (1 << PIX_W) - 1)) : i + 1);
    cap = capture_en;
    if (cap) begin
      if (model_idle) begin
`ifdef CMV_CAPTURE_HEADER_EN
        if (0 >= ff_from && 0 <= ff_to) exp_ovf = 1'b1;
        else exp_q.push_back({HEADER_MAGIC, 16'(exp_frames)});
`endif
        model_idle = 1'b0;
      end
      for (int w = 0; w * int'(PPW) < n; w++) begin
        logic [31:0] word;
        int first, last, done_at;
        word  = '0;
        first = w * int'(PPW);
        last  = (first + int'(PPW) < n) ? first + int'(PPW) : n;
        for (int j = first; j < last; j++)
          word = word | (32'(px[j]) << ((j - first) * int'(PIX_W)));
        done_at = (last - first == int'(PPW)) ? last - 1 : n;
        if (done_at >= ff_from && done_at <= ff_to) exp_ovf = 1'b1;
        else exp_q.push_back(word);
      end
      exp_lines++;
    end
    for (int i = 0; i < n; i++) begin
      if (i == ff_from) begin settle(); fifo_bus.fifo_full = 1'b1; end
      if (i == dis_at) capture_en = 1'b0;
      sensor_tick(1'b1, 1'b1, PIX_W'(px[i]));
      if (i == ff_to) begin settle(); fifo_bus.fifo_full = 1'b0; end
    end
    if (n == ff_from) begin settle(); fifo_bus.fifo_full = 1'b1; end
    sensor_tick(1'b0, 1'b0, '0);
    settle();
    fifo_bus.fifo_full = 1'b0;
    if (!capture_en) model_idle = 1'b1;
    check_eq("line_count", 32'(line_count), 32'(exp_lines));
    check_eq("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // FRAME_GAP idle ticks end the frame; one fewer must not.
  task automatic end_frame();
    idle_ticks(int'(GAP) - 1);
    settle();
    check_eq("usb_ready_before_gap", 32'(usb_ready), 32'd0);
    idle_ticks(1);
    settle();
    exp_frames++;
    exp_lines  = 0;
    model_idle = 1'b1;
    check_eq("usb_ready_frame_end", 32'(usb_ready), 32'd1);
    check_eq("frame_count", 32'(frame_count), 32'(exp_frames));
    check_eq("line_count_frame_end", 32'(line_count), 32'd0);
    @(negedge clk); fifo_bus.fifo_bt = 1'b1;
    @(negedge clk); fifo_bus.fifo_bt = 1'b0;
    check_eq("usb_ready_after_bt", 32'(usb_ready), 32'd0);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_wr_en", 32'(fifo_bus.fifo_wr_en), 32'd0);
    check_eq("rst_din", fifo_bus.fifo_din, 32'd0);
    check_eq("rst_usb_ready", 32'(usb_ready), 32'd0);
    check_eq("rst_frame_count", 32'(frame_count), 32'd0);
    check_eq("rst_line_count", 32'(line_count), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cmv_clk_out = 1'b0; cmv_lval = 1'b0; cmv_dval = 1'b0; cmv_d = '0;
    capture_en = 1'b0; fifo_bus.fifo_full = 1'b0; fifo_bus.fifo_bt = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset_n = 1'b1;
    set_en(1'b1);

    // Counting pixels 1..9 (three full words), then 1..7 (two words + flush).
    send_line(9, -1, -1, 1'b0, -1);
    idle_ticks(2);
    send_line(7, -1, -1, 1'b0, -1);
    idle_ticks(2);
    send_line(5, -1, -1, 1'b1, -1);
    idle_ticks(1);
    send_line(12, -1, -1, 1'b1, -1);
    end_frame();

    // FIFO full only while the second word completes; later words still land.
    send_line(9, 3, 5, 1'b0, -1);
    idle_ticks(2);
    send_line(4, -1, -1, 1'b1, -1);
    end_frame();
    set_en(1'b0);
    set_en(1'b1);
    check_eq("overflow_cleared_by_enable", 32'(overflow), 32'd0);

    // Random lines with occasional full FIFO across two frames.
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < 4; l++) begin
        int  n;
        bit  full;
        n    = int'($urandom_range(1, 11));
        full = ($urandom_range(0, 3) == 0);
        send_line(n, full ? 0 : -1, full ? n : -1, 1'b1, -1);
        if (l < 3) idle_ticks(int'($urandom_range(1, 3)));
      end
      end_frame();
    end
    set_en(1'b0);
    set_en(1'b1);

    // capture_en drops mid-line: the line and its flush complete, then capture stops.
    send_line(5, -1, -1, 1'b1, 3);
    idle_ticks(2);
    send_line(4, -1, -1, 1'b1, -1);
    set_en(1'b1);
    send_line(6, -1, -1, 1'b1, -1);
    end_frame();

    // Reset after two pixels: partial word discarded, outputs back to reset values.
`ifdef CMV_CAPTURE_HEADER_EN
    exp_q.push_back({HEADER_MAGIC, 16'(exp_frames)});
`endif
    sensor_tick(1'b1, 1'b1, 10'd100);
    sensor_tick(1'b1, 1'b1, 10'd200);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    check_eq("reset_pending_words", 32'(exp_q.size()), 32'd0);
    exp_lines = 0; exp_frames = 0; exp_ovf = 1'b0; model_idle = 1'b1;
    reset_n = 1'b1;
    sensor_tick(1'b0, 1'b0, '0);
    settle();
    send_line(3, -1, -1, 1'b1, -1);
    end_frame();

    settle();
    check_eq("words_outstanding", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmv_capture_packer.md
CMV_CAPTURE_PACKER -- requirements
Module: cmv_capture_packer

Interface
REQ-001 SHALL have parameter PIX_W, default 10, pixel width in bits (1..16).
REQ-002 SHALL have parameter PIX_PER_WORD, default 3, pixels packed per FIFO word; PIX_W*PIX_PER_WORD <= 32 is required and checked at elaboration.
REQ-003 SHALL have parameter FRAME_GAP, default 64, the number of consecutive idle sensor clocks that ends a frame (2..65535).
REQ-004 clk  in  1  system clock; the only clock.
REQ-005 reset_n  in  1  reset, synchronous, active-low.
REQ-006 cmv_clk_out  in  1  sensor pixel clock, asynchronous; sampled as data.
REQ-007 cmv_lval, cmv_dval  in  1 each  sensor line-valid and data-valid.
REQ-008 cmv_d  in  PIX_W  sensor pixel data.
REQ-009 capture_en  in  1  enables capture; level-sensitive.
REQ-010 fifo_full  in  1  downstream FIFO full.
REQ-011 fifo_bt  in  1  downstream block-transfer acknowledge; clears usb_ready.
REQ-012 fifo_wr_en  out  1  one-cycle write strobe.
REQ-013 fifo_din  out  32  packed word, valid while fifo_wr_en is high.
REQ-014 usb_ready  out  1  frame complete, data available for USB readout.
REQ-015 frame_count  out  16  completed frames; wraps.
REQ-016 line_count  out  16  lines in the current frame.
REQ-017 overflow  out  1  sticky flag for a word dropped because the FIFO was full.

Function
REQ-018 SHALL pass cmv_clk_out, cmv_lval, cmv_dval and cmv_d through a 2-flop synchroniser and detect the rising edge of the synchronised clock; every rule below acts only on a detected edge ("tick").
REQ-019 SHALL implement states IDLE, LINE, GAP and FLUSH; on reset the state SHALL be IDLE.
REQ-020 In IDLE with capture_en=1, a tick with lval&dval SHALL capture the pixel and go to LINE; in IDLE with capture_en=0, no pixel SHALL be captured.
REQ-021 In LINE, each tick with lval&dval SHALL place the pixel in slot k of the pack register at bits [k*PIX_W +: PIX_W], with k starting at 0; unused upper bits SHALL be 0.
REQ-022 When slot PIX_PER_WORD-1 is filled, the block SHALL assert fifo_wr_en for exactly one clk cycle, one cycle after that tick, and reset k to 0.
REQ-023 A tick with lval=0 in LINE SHALL increment line_count and go to FLUSH if k>0, or to GAP otherwise.
REQ-024 FLUSH SHALL write the partial word, with its unfilled slots zero, in one cycle, then go to GAP; a line SHALL never share a word with the next line.
REQ-025 GAP SHALL count consecutive ticks with lval=0 and dval=0; lval&dval SHALL clear the count and return to LINE.
REQ-026 When the idle count reaches FRAME_GAP, the block SHALL set usb_ready, increment frame_count, clear line_count and go to IDLE.
REQ-027 fifo_bt=1 SHALL clear usb_ready on the next clk edge; if it coincides with a frame-end set, the set SHALL win.
REQ-028 A write strobe while fifo_full=1 SHALL be suppressed and SHALL set overflow; overflow SHALL clear only on reset or a capture_en rising edge.
REQ-029 Deassertion of capture_en mid-line SHALL finish the current line, including its flush, before going to IDLE.
REQ-030 At most one FIFO write SHALL occur per clk cycle; a full word and a flush SHALL never be issued in the same cycle.

Reset
REQ-031 With reset_n=0 at a clk edge: fifo_wr_en=0, fifo_din=0, usb_ready=0, frame_count=0, line_count=0, overflow=0, k=0, idle count=0, synchronisers=0, state IDLE.
REQ-032 Reset asserted mid-line SHALL discard the partial word without writing it.

Configuration
REQ-033 Macro CMV_CAPTURE_HEADER_EN: when defined, the first pixel of each frame SHALL be preceded by one header word {16'hA5C3, frame_count}, subject to the REQ-028 full rule.
REQ-034 Without CMV_CAPTURE_HEADER_EN, no header SHALL be written and the FIFO stream SHALL contain pixel words only.

Structure
REQ-035 Package cmv_capture_pkg SHALL hold the state enum, the header magic 16'hA5C3 and a width-check function.
REQ-036 The synchroniser and edge detector SHALL form sub-module cmv_sync_edge, instantiated once.

Verification
REQ-037 Line of 9 pixels 1..9 with PIX_W=10 and PIX_PER_WORD=3 -> 3 words; word0 = {2'b0, 10'd3, 10'd2, 10'd1}.
REQ-038 Line of 7 pixels -> 2 full words, then a flush word {20'b0, 10'd7}; line_count=1.
REQ-039 4 lines followed by 64 idle ticks -> usb_ready=1, frame_count=1, line_count=0; fifo_bt pulse -> usb_ready=0 next cycle.
REQ-040 fifo_full held high during the 2nd word -> that word is absent, overflow=1, and later words are still written.
REQ-041 Reset pulsed after 2 pixels of a line -> no write issued, all outputs at reset values.
REQ-042 With CMV_CAPTURE_HEADER_EN, 2 frames -> headers 32'hA5C3_0000 and 32'hA5C3_0001, each ahead of its frame's pixel words.
